// File: rtl/mac4x4_seq_ctrl.sv
// Sequencer for the 4x4 weight-stationary MAC array: loads four weight rows, streams
// skewed input vectors, counts finished output rows and reports completion or timeout.
//
// state  | meaning
// S_IDLE   | waiting for start
// S_WLOAD  | weight-row fetch and load, 5 cycles
// S_STREAM | input-vector issue, one per cycle
// S_DRAIN  | skew pipe empties, waiting for remaining output rows
// S_FIN    | one-cycle done pulse
module mac4x4_seq_ctrl #(
    parameter int NR_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NR_W-1:0] nrows,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      wbuf_raddr,
    input  logic [31:0]     wbuf_rdata,
    output logic [NR_W-1:0] ibuf_raddr,
    input  logic [31:0]     ibuf_rdata,
    output logic            w_load,
    output logic [1:0]      wrow,
    output logic [31:0]     wdata,
    output logic [31:0]     idata,
    output logic [3:0]      icol_valid,
    input  logic [3:0]      ovalid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [2:0]      k_cnt;
    logic [NR_W-1:0] n_cnt;
    logic [NR_W-1:0] nrows_q;
    logic [NR_W-1:0] out_cnt;
    logic [TW-1:0]   idle_tmr;
    logic            err_q;

    // Skew pipe entries are {valid, byte}; column j sits behind j register stages.
    logic            v0_q;
    logic [8:0]      c1_q;
    logic [1:0][8:0] c2_q;
    logic [2:0][8:0] c3_q;

    logic start_ok;
    logic pipe_empty;
    logic tmr_run;
    logic timeout;
    logic stream_last;
    logic act;
    logic [2:0] k_m1;
    logic unused_ovalid;

    assign unused_ovalid = ^ovalid[2:0];

    assign start_ok    = (state == S_IDLE) && start;
    assign pipe_empty  = !v0_q && !c1_q[8] && !c2_q[0][8] && !c2_q[1][8]
                         && !c3_q[0][8] && !c3_q[1][8] && !c3_q[2][8];
    assign tmr_run     = (state == S_DRAIN) && pipe_empty && !ovalid[3];
    assign timeout     = tmr_run && (idle_tmr == TW'(1));
    assign stream_last = (n_cnt == nrows_q - NR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_WLOAD;
            S_WLOAD:  if (k_cnt == 3'd4) state_nx = (nrows_q == '0) ? S_FIN : S_STREAM;
            S_STREAM: if (stream_last) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (timeout || (pipe_empty && (out_cnt == nrows_q))) state_nx = S_FIN;
            end
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt    <= '0;
            n_cnt    <= '0;
            nrows_q  <= '0;
            out_cnt  <= '0;
            idle_tmr <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                k_cnt   <= '0;
                n_cnt   <= '0;
                nrows_q <= nrows;
                out_cnt <= '0;
                err_q   <= 1'b0;
            end else begin
                if (state == S_WLOAD) k_cnt <= k_cnt + 3'd1;
                if (state == S_STREAM) n_cnt <= n_cnt + NR_W'(1);
                if ((state != S_IDLE) && ovalid[3] && (out_cnt != nrows_q))
                    out_cnt <= out_cnt + NR_W'(1);
                if (timeout) err_q <= 1'b1;
            end
            // Idle timer reloads whenever it is not actively counting a quiet drain cycle.
            if (tmr_run) idle_tmr <= idle_tmr - TW'(1);
            else         idle_tmr <= TW'(TIMEOUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else if (timeout) begin
            v0_q <= 1'b0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else begin
            v0_q    <= (state == S_STREAM);
            c1_q    <= {v0_q, ibuf_rdata[23:16]};
            c2_q[0] <= {v0_q, ibuf_rdata[15:8]};
            c2_q[1] <= c2_q[0];
            c3_q[0] <= {v0_q, ibuf_rdata[7:0]};
            c3_q[1] <= c3_q[0];
            c3_q[2] <= c3_q[1];
        end
    end

    assign k_m1  = k_cnt - 3'd1;
    assign act   = (state == S_STREAM) || (state == S_DRAIN);
    assign wdata = wbuf_rdata;

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_FIN);
        err        = err_q;
        w_load     = (state == S_WLOAD) && (k_cnt != 3'd0);
        wrow       = w_load ? k_m1[1:0] : 2'd0;
        wbuf_raddr = ((state == S_WLOAD) && (k_cnt < 3'd4)) ? k_cnt[1:0] : 2'd0;
        ibuf_raddr = (state == S_STREAM) ? n_cnt : '0;
        icol_valid = 4'b0000;
        idata      = 32'h0;
        if (act) begin
            icol_valid = {c3_q[2][8], c2_q[1][8], c1_q[8], v0_q};
            idata      = {v0_q       ? ibuf_rdata[31:24] : 8'h00,
                          c1_q[8]    ? c1_q[7:0]         : 8'h00,
                          c2_q[1][8] ? c2_q[1][7:0]      : 8'h00,
                          c3_q[2][8] ? c3_q[2][7:0]      : 8'h00};
        end
    end

endmodule
